line_delay_mc: RTL
==================

Name: line_delay_mc

Overview:
- Multi-channel (FLUX) row-delay actor for the HEVC dataflow: per channel it reads a block descriptor (width W, height H), then streams W*H samples.
- Each output is the sample from DELAY_LINES rows earlier in the same column.
- Successor of the single-line delay actor. Adds parametrised depth, width and line length, round-robin channel arbitration, a fill mode for the first rows, and descriptor error checking.

Parameters:
- FLUX, 2, number of independent channels (tags).
- DATA_WIDTH, 18, sample width.
- SIZE_WIDTH, 7, width of W and H descriptor fields.
- MAX_W, 64, maximum line length (columns) per channel.
- DELAY_LINES, 1, row delay D (1..4).
- FILL_MODE, 0, 0 = output stale memory contents for rows < D; 1 = output FILL_VALUE for rows < D.
- FILL_VALUE, 0, DATA_WIDTH constant used when FILL_MODE=1.
- TAG_WIDTH, max(1,$clog2(FLUX)), derived; do not override.

Ports:
- clk  in  1  clock
- rst  in  1  reset
- a_empty  in  FLUX  sample FIFO empty, per channel
- a_dout  in  DATA_WIDTH+TAG_WIDTH  sample; low DATA_WIDTH bits used
- a_read  out  FLUX  sample pop, one-hot or zero
- w_empty  in  FLUX  width FIFO empty
- w_dout  in  SIZE_WIDTH+TAG_WIDTH  W in low bits
- w_read  out  FLUX  width pop
- h_empty  in  FLUX  height FIFO empty
- h_dout  in  SIZE_WIDTH+TAG_WIDTH  H in low bits
- h_read  out  FLUX  height pop
- o_full  in  1  output FIFO full
- o_din  out  DATA_WIDTH+TAG_WIDTH  {tag, delayed sample}
- o_write  out  1  output push
- err_size  out  FLUX  sticky per-channel descriptor error

Behaviour:
- Reset: rst is synchronous, active-high; clock clk.
  - All channels go to IDLE; counters, row pointers and err_size clear to 0.
  - All memory words clear to 0.
  - Arbiter last-grant = FLUX-1, so channel 0 has first priority.
  - Combinational outputs are 0 while no channel is eligible.
  - Reset mid-block aborts the block; no partial flush.
- Eligibility, channel i:
  - (IDLE & !w_empty[i] & !h_empty[i]), or
  - (WORK & !a_empty[i] & !o_full).
- Arbitration:
  - Round-robin, searching from last-grant+1. At most one channel is served per cycle.
  - Last-grant updates only when a channel is served.
  - All read/write strobes are combinational, same cycle: zero-latency actor.
- IDLE service:
  - Pop w and h together.
  - If 1<=W<=MAX_W and H>=1: latch W and H, cnt_h=cnt_v=0, row pointer rp=0, go to WORK.
  - Otherwise: descriptor dropped, err_size[i] set, stay IDLE.
- WORK service:
  - Pop a, push o. Memory address = rp*MAX_W + cnt_h.
  - o_din data = FILL_VALUE if (FILL_MODE=1 & cnt_v<D), else mem[addr] (read-before-write).
  - Same cycle, mem[addr] <= sample.
- Counter update on each WORK service:
  - cnt_h<W-1: cnt_h+1.
  - Else if cnt_v<H-1: cnt_h=0, cnt_v+1, rp=(rp+1) mod D.
  - Else: counters clear, go to IDLE. The next descriptor may be served on the following cycle.
- Non-granted channels hold all state.
- o_full blocks all WORK service but does not block IDLE descriptor pops.
- Stale mode (FILL_MODE=0): rows < D return the previous block's or reset contents.
- Memory per channel: D*MAX_W words of DATA_WIDTH, register array.

Decomposition:
- Package hevc_lb_pkg:
  - state enum {IDLE, WORK};
  - tag-width function;
  - descriptor struct {W, H}.
- Sub-module rr_arbiter: parameter N; inputs req[N] and advance; output one-hot gnt and index. Owns the last-grant register.

Test Plan:
- FLUX=1, D=1, FILL_MODE=0: descriptor W=4, H=3, samples 1..12 → outputs 0,0,0,0,1,2,3,4,5,6,7,8; state IDLE after 12th pop.
- D=2, FILL_MODE=1, FILL_VALUE=0x3FFFF: W=2, H=4, samples 1..8 → 3FFFF×4, then 1,2,3,4.
- FLUX=2: both channels always eligible, W=2, H=2 each → grants alternate 0,1,0,1…; o_din tag matches granted channel; each channel's data is independent.
- o_full held high 5 cycles mid-row → no a_read, no o_write, counters frozen; the stream resumes exactly where it stopped.
- Descriptor W=0 (and W=MAX_W+1) → w/h popped, err_size[ch]=1, channel stays IDLE, and a following valid descriptor runs normally.
- rst asserted after 3 of 12 samples → all outputs 0 next cycle, memory zero; a new block outputs zeros for its first row.

Source files
------------

// File: rtl/hevc_lb_pkg.sv
// Shared types and helpers for the HEVC line-buffer actors.
package hevc_lb_pkg;

  // Per-channel actor state.
  typedef enum logic [0:0] {StIdle, StWork} state_e;

  // Descriptor fields are held at a generous fixed width and zero-extended from the FIFOs.
  localparam int unsigned MaxSizeWidth = 16;

  typedef struct packed {
    logic [MaxSizeWidth-1:0] w;
    logic [MaxSizeWidth-1:0] h;
  } desc_t;

  // Index width for n items, never below one bit.
  function automatic int unsigned tag_width(input int unsigned n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: searches from the last grant + 1 and owns the last-grant register.
module rr_arbiter import hevc_lb_pkg::*; #(
  parameter int unsigned N    = 2,
  parameter int unsigned IdxW = tag_width(N)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [N-1:0]    req,
  input  logic            advance,
  output logic [N-1:0]    gnt,
  output logic [IdxW-1:0] idx
);

  logic [IdxW-1:0] last_q;
  logic [IdxW-1:0] cand;
  logic            found;

  // Pick the first requester after the previous winner, wrapping around.
  always_comb begin
    gnt   = '0;
    idx   = '0;
    cand  = '0;
    found = 1'b0;
    for (int unsigned k = 1; k <= N; k++) begin
      cand = IdxW'((32'(last_q) + k) % N);
      if (!found && req[cand]) begin
        found     = 1'b1;
        idx       = cand;
        gnt[cand] = 1'b1;
      end
    end
  end

  // Reset to N-1 so channel 0 has first priority; move only when a channel is served.
  always_ff @(posedge clk) begin
    if (rst) begin
      last_q <= IdxW'(N - 1);
    end else if (advance) begin
      last_q <= idx;
    end
  end

endmodule

// File: rtl/line_delay_mc.sv
// Multi-channel row-delay actor: each output is the sample DELAY_LINES rows above in the
// same column. Zero-latency: all FIFO strobes are combinational on the served channel.
module line_delay_mc import hevc_lb_pkg::*; #(
  parameter int unsigned          FLUX        = 2,
  parameter int unsigned          DATA_WIDTH  = 18,
  parameter int unsigned          SIZE_WIDTH  = 7,
  parameter int unsigned          MAX_W       = 64,
  parameter int unsigned          DELAY_LINES = 1,
  parameter int unsigned          FILL_MODE   = 0,
  parameter logic [DATA_WIDTH-1:0] FILL_VALUE = '0,
  parameter int unsigned          TAG_WIDTH   = tag_width(FLUX)
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic [FLUX-1:0]                  a_empty,
  input  logic [DATA_WIDTH+TAG_WIDTH-1:0]  a_dout,
  output logic [FLUX-1:0]                  a_read,
  input  logic [FLUX-1:0]                  w_empty,
  input  logic [SIZE_WIDTH+TAG_WIDTH-1:0]  w_dout,
  output logic [FLUX-1:0]                  w_read,
  input  logic [FLUX-1:0]                  h_empty,
  input  logic [SIZE_WIDTH+TAG_WIDTH-1:0]  h_dout,
  output logic [FLUX-1:0]                  h_read,
  input  logic                             o_full,
  output logic [DATA_WIDTH+TAG_WIDTH-1:0]  o_din,
  output logic                             o_write,
  output logic [FLUX-1:0]                  err_size
);

  localparam int unsigned CntW  = tag_width(MAX_W);
  localparam int unsigned RpW   = tag_width(DELAY_LINES);
  localparam int unsigned Depth = DELAY_LINES * MAX_W;
  localparam int unsigned AddrW = tag_width(Depth);

  state_e                 state_q [FLUX];
  logic [SIZE_WIDTH-1:0]  w_q     [FLUX];
  logic [SIZE_WIDTH-1:0]  h_q     [FLUX];
  logic [CntW-1:0]        cnt_h_q [FLUX];
  logic [SIZE_WIDTH-1:0]  cnt_v_q [FLUX];
  logic [RpW-1:0]         rp_q    [FLUX];
  logic [FLUX-1:0]        err_q;
  logic [DATA_WIDTH-1:0]  mem_q   [FLUX][Depth];

  logic [FLUX-1:0]        req;
  logic [FLUX-1:0]        gnt;
  logic [TAG_WIDTH-1:0]   gnt_idx;
  logic                   any_gnt;

  desc_t                  desc;
  logic                   desc_ok;
  state_e                 state_d;
  logic [SIZE_WIDTH-1:0]  w_d, h_d, cnt_v_d;
  logic [CntW-1:0]        cnt_h_d;
  logic [RpW-1:0]         rp_d;
  logic                   err_set;
  logic [AddrW-1:0]       addr;
  logic [DATA_WIDTH-1:0]  out_data;

  // Tag fields on the input FIFOs carry no information for this actor.
  logic unused_tags;
  assign unused_tags = ^{a_dout[DATA_WIDTH+:TAG_WIDTH], w_dout[SIZE_WIDTH+:TAG_WIDTH],
                         h_dout[SIZE_WIDTH+:TAG_WIDTH]};

  // A channel can be served when its descriptor pair or its sample-plus-output slot is ready.
  always_comb begin
    req = '0;
    for (int i = 0; i < FLUX; i++) begin
      req[i] = (state_q[i] == StIdle && !w_empty[i] && !h_empty[i]) ||
               (state_q[i] == StWork && !a_empty[i] && !o_full);
    end
  end

  rr_arbiter #(
    .N    (FLUX),
    .IdxW (TAG_WIDTH)
  ) u_arb (
    .clk     (clk),
    .rst     (rst),
    .req     (req),
    .advance (any_gnt),
    .gnt     (gnt),
    .idx     (gnt_idx)
  );

  assign any_gnt  = |gnt;
  assign err_size = err_q;
  assign addr     = AddrW'(32'(rp_q[gnt_idx]) * MAX_W + 32'(cnt_h_q[gnt_idx]));

  // Delayed sample for the served channel; optionally masked during the first D rows.
  always_comb begin
    if (FILL_MODE == 1 && 32'(cnt_v_q[gnt_idx]) < DELAY_LINES) begin
      out_data = FILL_VALUE;
    end else begin
      out_data = mem_q[gnt_idx][addr];
    end
  end

  // Next state and counters for the served channel.
  always_comb begin
    desc.w  = MaxSizeWidth'(w_dout[SIZE_WIDTH-1:0]);
    desc.h  = MaxSizeWidth'(h_dout[SIZE_WIDTH-1:0]);
    desc_ok = (desc.w != '0) && (32'(desc.w) <= MAX_W) && (desc.h != '0);
    state_d = state_q[gnt_idx];
    w_d     = w_q[gnt_idx];
    h_d     = h_q[gnt_idx];
    cnt_h_d = cnt_h_q[gnt_idx];
    cnt_v_d = cnt_v_q[gnt_idx];
    rp_d    = rp_q[gnt_idx];
    err_set = 1'b0;
    if (any_gnt) begin
      if (state_q[gnt_idx] == StIdle) begin
        if (desc_ok) begin
          state_d = StWork;
          w_d     = SIZE_WIDTH'(desc.w);
          h_d     = SIZE_WIDTH'(desc.h);
          cnt_h_d = '0;
          cnt_v_d = '0;
          rp_d    = '0;
        end else begin
          err_set = 1'b1;
        end
      end else if (32'(cnt_h_q[gnt_idx]) + 1 < 32'(w_q[gnt_idx])) begin
        cnt_h_d = cnt_h_q[gnt_idx] + CntW'(1);
      end else if (32'(cnt_v_q[gnt_idx]) + 1 < 32'(h_q[gnt_idx])) begin
        cnt_h_d = '0;
        cnt_v_d = cnt_v_q[gnt_idx] + SIZE_WIDTH'(1);
        rp_d    = (32'(rp_q[gnt_idx]) + 1 == DELAY_LINES) ? '0 : rp_q[gnt_idx] + RpW'(1);
      end else begin
        cnt_h_d = '0;
        cnt_v_d = '0;
        rp_d    = '0;
        state_d = StIdle;
      end
    end
  end

  // FIFO strobes and output word, all zero unless a channel is served.
  always_comb begin
    a_read  = '0;
    w_read  = '0;
    h_read  = '0;
    o_write = 1'b0;
    o_din   = '0;
    if (any_gnt) begin
      if (state_q[gnt_idx] == StIdle) begin
        w_read = gnt;
        h_read = gnt;
      end else begin
        a_read  = gnt;
        o_write = 1'b1;
        o_din   = {gnt_idx, out_data};
      end
    end
  end

  // State, counters and line memory; only the served channel changes.
  always_ff @(posedge clk) begin
    if (rst) begin
      err_q <= '0;
      for (int i = 0; i < FLUX; i++) begin
        state_q[i] <= StIdle;
        w_q[i]     <= '0;
        h_q[i]     <= '0;
        cnt_h_q[i] <= '0;
        cnt_v_q[i] <= '0;
        rp_q[i]    <= '0;
        for (int j = 0; j < Depth; j++) begin
          mem_q[i][j] <= '0;
        end
      end
    end else if (any_gnt) begin
      state_q[gnt_idx] <= state_d;
      w_q[gnt_idx]     <= w_d;
      h_q[gnt_idx]     <= h_d;
      cnt_h_q[gnt_idx] <= cnt_h_d;
      cnt_v_q[gnt_idx] <= cnt_v_d;
      rp_q[gnt_idx]    <= rp_d;
      if (err_set) begin
        err_q[gnt_idx] <= 1'b1;
      end
      // Read-before-write: out_data above already sampled the old word.
      if (state_q[gnt_idx] == StWork) begin
        mem_q[gnt_idx][addr] <= a_dout[DATA_WIDTH-1:0];
      end
    end
  end

endmodule
